// File: rtl/fetch_unit_pkg.sv
// Shared encodings for the instruction fetch unit: redirect sources, vector
// addresses and FSM state codes.
package fetch_unit_pkg;

  // Halfword addresses of the 32-bit reset and interrupt pointers.
  localparam logic [31:0] RstVec = 32'h0000_0000;
  localparam logic [31:0] IntVec = 32'h0000_0002;

  typedef enum logic [1:0] {
    SrcRst = 2'b00,
    SrcInt = 2'b01,
    SrcBr  = 2'b10,
    SrcRet = 2'b11
  } fetch_src_e;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StPtrLo = 3'd1;
  localparam logic [2:0] StPtrHi = 3'd2;
  localparam logic [2:0] StInsLo = 3'd3;
  localparam logic [2:0] StInsHi = 3'd4;
  localparam logic [2:0] StOut   = 3'd5;

  // Bit 15 of the first halfword marks a 32-bit instruction.
  function automatic logic is_long_instr(input logic [15:0] hw);
    return hw[15];
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of redirect command, instruction memory and decode handshake signals.
// The fetch unit uses the slave view; its environment uses the master view.
interface fetch_unit_if;
  logic        fetch;
  logic [1:0]  fetch_src;
  logic        extend;
  logic [31:0] br_target;
  logic [31:0] ret_target;
  logic [31:0] imem_addr;
  logic        imem_rd;
  logic [15:0] imem_data;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ext;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    output fetch, fetch_src, extend, br_target, ret_target, imem_data, instr_ready,
    input  imem_addr, imem_rd, instr, instr_pc, instr_ext, instr_valid
  );

  modport slave (
    input  fetch, fetch_src, extend, br_target, ret_target, imem_data, instr_ready,
    output imem_addr, imem_rd, instr, instr_pc, instr_ext, instr_valid
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch datapath: owns the PC, follows vector pointers on request,
// assembles 16/32-bit instructions from halfword reads and hands them to decode.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input logic         clk_i,
  input logic         rst_ni,
  fetch_unit_if.slave fu_bus
);

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ptr_q, ptr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_ext_q, instr_ext_d;
  logic [31:0] src_addr;

  // Redirect source selection.
  always_comb begin
    unique case (fetch_src_e'(fu_bus.fetch_src))
      SrcRst:  src_addr = RstVec;
      SrcInt:  src_addr = IntVec;
      SrcBr:   src_addr = fu_bus.br_target;
      SrcRet:  src_addr = fu_bus.ret_target;
      default: src_addr = RstVec;
    endcase
  end

  // Next-state logic; a redirect overrides whatever the current state would do.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ptr_d       = ptr_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    instr_ext_d = instr_ext_q;
    if (fu_bus.fetch) begin
      if (fu_bus.extend) begin
        ptr_d   = src_addr;
        state_d = StPtrLo;
      end else begin
        pc_d    = src_addr;
        state_d = StInsLo;
      end
    end else begin
      case (state_q)
        StIdle: ;
        StPtrLo: begin
          pc_d[31:16] = fu_bus.imem_data;
          state_d     = StPtrHi;
        end
        StPtrHi: begin
          pc_d[15:0] = fu_bus.imem_data;
          state_d    = StInsLo;
        end
        StInsLo: begin
          if (is_long_instr(fu_bus.imem_data)) begin
            instr_d[31:16] = fu_bus.imem_data;
            state_d        = StInsHi;
          end else begin
            instr_d     = {16'h0000, fu_bus.imem_data};
            instr_pc_d  = pc_q;
            instr_ext_d = 1'b0;
            pc_d        = pc_q + 32'd1;
            state_d     = StOut;
          end
        end
        StInsHi: begin
          instr_d[15:0] = fu_bus.imem_data;
          instr_pc_d    = pc_q;
          instr_ext_d   = 1'b1;
          pc_d          = pc_q + 32'd2;
          state_d       = StOut;
        end
        StOut: begin
          if (fu_bus.instr_ready) state_d = StInsLo;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      pc_q        <= 32'h0;
      ptr_q       <= 32'h0;
      instr_q     <= 32'h0;
      instr_pc_q  <= 32'h0;
      instr_ext_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ptr_q       <= ptr_d;
      instr_q     <= instr_d;
      instr_pc_q  <= instr_pc_d;
      instr_ext_q <= instr_ext_d;
    end
  end

  // Memory address/strobe decoded from the current state only.
  always_comb begin
    fu_bus.imem_rd   = 1'b1;
    fu_bus.imem_addr = 32'h0;
    case (state_q)
      StPtrLo: fu_bus.imem_addr = ptr_q;
      StPtrHi: fu_bus.imem_addr = ptr_q + 32'd1;
      StInsLo: fu_bus.imem_addr = pc_q;
      StInsHi: fu_bus.imem_addr = pc_q + 32'd1;
      default: fu_bus.imem_rd   = 1'b0;
    endcase
  end

  assign fu_bus.instr       = instr_q;
  assign fu_bus.instr_pc    = instr_pc_q;
  assign fu_bus.instr_ext   = instr_ext_q;
  assign fu_bus.instr_valid = (state_q == StOut);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. The reference model works at transaction
// level: a redirect or an accepted instruction expands into the list of halfword
// reads that must follow, and the instruction decode must then see.
module tb_fetch_unit;

  logic clk;
  logic rst_n;
  fetch_unit_if bus ();

  logic [15:0] mem [256];
  assign bus.imem_data = mem[bus.imem_addr[7:0]];

  fetch_unit dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .fu_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Model state.
  logic [31:0] rq [$];
  bit          m_valid;
  logic [31:0] exp_instr, exp_pc, next_pc;
  logic        exp_ext;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  function automatic logic [15:0] mem_rd(input logic [31:0] a);
    return mem[a[7:0]];
  endfunction

  // Queue the reads for the instruction at pc and record what decode must get.
  task automatic plan_instr(input logic [31:0] pc);
    logic [15:0] h;
    h = mem_rd(pc);
    rq.push_back(pc);
    exp_pc = pc;
    if (h[15]) begin
      rq.push_back(pc + 32'd1);
      exp_instr = {h, mem_rd(pc + 32'd1)};
      exp_ext   = 1'b1;
      next_pc   = pc + 32'd2;
    end else begin
      exp_instr = {16'h0000, h};
      exp_ext   = 1'b0;
      next_pc   = pc + 32'd1;
    end
  endtask

  task automatic model_reset();
    rq.delete();
    m_valid = 1'b0;
  endtask

  // Advance the model by one clock using the inputs just driven.
  task automatic model_advance();
    logic [31:0] src;
    if (bus.fetch) begin
      rq.delete();
      m_valid = 1'b0;
      case (bus.fetch_src)
        2'b00:   src = 32'h0;
        2'b01:   src = 32'h2;
        2'b10:   src = bus.br_target;
        default: src = bus.ret_target;
      endcase
      if (bus.extend) begin
        rq.push_back(src);
        rq.push_back(src + 32'd1);
        plan_instr({mem_rd(src), mem_rd(src + 32'd1)});
      end else begin
        plan_instr(src);
      end
    end else if (rq.size() != 0) begin
      void'(rq.pop_front());
      if (rq.size() == 0) m_valid = 1'b1;
    end else if (m_valid && bus.instr_ready) begin
      m_valid = 1'b0;
      plan_instr(next_pc);
    end
  endtask

  task automatic compare();
    chk("imem_rd", {31'b0, bus.imem_rd}, {31'b0, rq.size() != 0});
    chk("imem_addr", bus.imem_addr, (rq.size() != 0) ? rq[0] : 32'h0);
    chk("instr_valid", {31'b0, bus.instr_valid}, {31'b0, m_valid});
    if (m_valid) begin
      chk("instr", bus.instr, exp_instr);
      chk("instr_pc", bus.instr_pc, exp_pc);
      chk("instr_ext", {31'b0, bus.instr_ext}, {31'b0, exp_ext});
    end
  endtask

  // One cycle: check this cycle's outputs, drive inputs, advance the model.
  task automatic step(input logic f, input logic [1:0] s, input logic e,
                      input logic [31:0] br, input logic [31:0] rt, input logic rdy);
    @(negedge clk);
    compare();
    bus.fetch       = f;
    bus.fetch_src   = s;
    bus.extend      = e;
    bus.br_target   = br;
    bus.ret_target  = rt;
    bus.instr_ready = rdy;
    model_advance();
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, rdy);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"}, bus.imem_addr, 32'h0);
    chk({tag, "_rd"}, {31'b0, bus.imem_rd}, 32'h0);
    chk({tag, "_valid"}, {31'b0, bus.instr_valid}, 32'h0);
    chk({tag, "_instr"}, bus.instr, 32'h0);
    chk({tag, "_pc"}, bus.instr_pc, 32'h0);
    chk({tag, "_ext"}, {31'b0, bus.instr_ext}, 32'h0);
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.fetch       = 1'b0;
    bus.fetch_src   = 2'b00;
    bus.extend      = 1'b0;
    bus.br_target   = 32'h0;
    bus.ret_target  = 32'h0;
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[8'h00] = 16'h0000; mem[8'h01] = 16'h0040;
    mem[8'h02] = 16'h0000; mem[8'h03] = 16'h0060;
    mem[8'h40] = 16'h1234; mem[8'h41] = 16'h0567; mem[8'h42] = 16'h0111;
    mem[8'h50] = 16'h8001; mem[8'h51] = 16'hBEEF;
    mem[8'h52] = 16'h8222; mem[8'h53] = 16'h3333;
    mem[8'h60] = 16'h0444; mem[8'hFF] = 16'h0555;
    model_reset();

    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Reset vector through pointer: reads at 0, 1, then 0x40.
    step(1'b1, 2'b00, 1'b1, 32'h0, 32'h0, 1'b1);
    idle(1'b1); chk("ptr_lo_addr", bus.imem_addr, 32'h0); chk("ptr_lo_rd", {31'b0, bus.imem_rd}, 32'h1);
    idle(1'b1); chk("ptr_hi_addr", bus.imem_addr, 32'h1);
    idle(1'b1); chk("first_ins_addr", bus.imem_addr, 32'h40);
    idle(1'b1); chk("i16a", bus.instr, 32'h0000_1234); chk("i16a_pc", bus.instr_pc, 32'h40);
    chk("i16a_ext", {31'b0, bus.instr_ext}, 32'h0);
    idle(1'b1);
    idle(1'b1); chk("i16b", bus.instr, 32'h0000_0567); chk("i16b_pc", bus.instr_pc, 32'h41);

    // Branch to a 32-bit instruction, then hold it for 5 cycles.
    step(1'b1, 2'b10, 1'b0, 32'h50, 32'h0, 1'b1);
    idle(1'b1);
    idle(1'b0); chk("i32_hi_addr", bus.imem_addr, 32'h51);
    idle(1'b0); chk("i32", bus.instr, 32'h8001_BEEF); chk("i32_ext", {31'b0, bus.instr_ext}, 32'h1);
    chk("i32_pc", bus.instr_pc, 32'h50);
    repeat (4) idle(1'b0);
    idle(1'b1); chk("hold_instr", bus.instr, 32'h8001_BEEF); chk("hold_rd", {31'b0, bus.imem_rd}, 32'h0);
    idle(1'b1); chk("after_i32_addr", bus.imem_addr, 32'h52);

    // Interrupt redirect while in INS_HI drops the partial instruction.
    step(1'b1, 2'b01, 1'b1, 32'h0, 32'h0, 1'b1); chk("ins_hi_addr", bus.imem_addr, 32'h53);
    idle(1'b1); chk("int_ptr_lo", bus.imem_addr, 32'h2); chk("int_no_valid", {31'b0, bus.instr_valid}, 32'h0);
    idle(1'b1); chk("int_ptr_hi", bus.imem_addr, 32'h3);
    idle(1'b1); chk("int_ins_addr", bus.imem_addr, 32'h60);

    // PC wrap at the top of the address space.
    step(1'b1, 2'b10, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1); chk("int_instr", bus.instr, 32'h0000_0444);
    idle(1'b1); chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFF);
    idle(1'b1); chk("wrap_pc", bus.instr_pc, 32'hFFFF_FFFF); chk("wrap_instr", bus.instr, 32'h0000_0555);

    // Reset asserted during PTR_HI clears outputs immediately.
    step(1'b1, 2'b00, 1'b1, 32'h0, 32'h0, 1'b1); chk("wrapped_addr", bus.imem_addr, 32'h0);
    idle(1'b1);
    idle(1'b1); chk("pre_rst_ptr_hi", bus.imem_addr, 32'h1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) idle(1'b1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 9) == 0), 2'($urandom), 1'($urandom),
           $urandom, $urandom, ($urandom_range(0, 9) < 7));
    end
    @(negedge clk);
    compare();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch datapath that consumes the `fetch`/`fetchSrc`/`extend` redirect commands from the fetch control stage and produces complete instructions for decode. It owns the PC, reads 16-bit halfwords from instruction memory, follows 32-bit vector pointers when told to, and assembles 16- or 32-bit instructions. Results go to decode over a valid/ready handshake.

## Interface
- `RST_VEC`, 32'h0000_0000: halfword address of the 32-bit reset pointer.
- `INT_VEC`, 32'h0000_0002: halfword address of the 32-bit interrupt pointer.
- `clk`  in  1  clock. All state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `fetch`  in  1  redirect command, one cycle wide.
- `fetchSrc`  in  2  redirect source. 00 RST (`RST_VEC`), 01 INT (`INT_VEC`), 10 BR (`brTarget`), 11 RET (`retTarget`).
- `extend`  in  1  qualifies `fetch`. 1 means the source is the address of a 32-bit pointer, and the new PC is read from memory. 0 means the source is the new PC itself.
- `brTarget`  in  32  branch target.
- `retTarget`  in  32  return address.
- `imemAddr`  out  32  halfword address.
- `imemRd`  out  1  read strobe.
- `imemData`  in  16  read data. Asynchronous read, valid in the same cycle as `imemAddr`.
- `instr`  out  32  instruction. A 16-bit instruction sits in bits [15:0] with [31:16] = 0. A 32-bit instruction has the first halfword in [31:16].
- `instrPC`  out  32  address of the first halfword of `instr`.
- `instrExt`  out  1  1 when `instr` is a 32-bit instruction.
- `instrValid`  out  1  `instr` is valid.
- `instrReady`  in  1  decode accepts `instr`.

## Operation
- States:
  - IDLE: no fetch.
  - PTR_LO / PTR_HI: read pointer halfwords.
  - INS_LO / INS_HI: read instruction halfwords.
  - OUT: hold the instruction for decode.
- Reset: state IDLE. `pc`, `ptr`, `instr`, `instrPC` = 0. `instrExt`, `instrValid`, `imemRd` = 0. `imemAddr` = 0.
- Redirect, `fetch`=1: highest priority in every state. It discards any partial pointer, partial instruction or held instruction.
  - `extend`=1: `ptr` is loaded with the selected source and the next state is PTR_LO.
  - `extend`=0: `pc` is loaded with the selected source and the next state is INS_LO.
- PTR_LO reads `imemData` at address `ptr` into `pc[31:16]`, then goes to PTR_HI.
- PTR_HI reads `ptr`+1 into `pc[15:0]`, then goes to INS_LO.
- INS_LO reads at address `pc`.
  - Bit 15 = 0: 16-bit instruction. `instr` ← {16'h0, data}, `instrPC` ← `pc`, `pc` ← `pc`+1, next state OUT.
  - Bit 15 = 1: 32-bit instruction. The halfword is latched into `instr[31:16]`, next state INS_HI.
- INS_HI reads `pc`+1 into `instr[15:0]`, sets `instrPC` ← `pc` and `pc` ← `pc`+2, then goes to OUT.
- OUT: `instrValid`=1. On `instrValid && instrReady` the next state is INS_LO. Otherwise `instr`, `instrPC` and `instrExt` hold stable.
- `imemRd`=1 exactly in the PTR_LO, PTR_HI, INS_LO and INS_HI states. Otherwise `imemAddr` is 0.
- All address arithmetic is 32-bit modulo 2^32: `pc`+1 at 32'hFFFF_FFFF wraps to 0, and `ptr`+1 wraps the same way.
- `instrValid` is 0 in every state other than OUT.

## Timing
- Redirect with `extend`=0 to the first `instrValid`:
  - 2 cycles for a 16-bit instruction (INS_LO, then OUT).
  - 3 cycles for a 32-bit instruction.
- Redirect with `extend`=1 adds 2 cycles for the pointer reads.
- Steady state, `instrReady` always 1: one 16-bit instruction every 2 cycles, one 32-bit instruction every 3 cycles.
- Redirect in OUT while `instrReady`=1: the transfer completes in that cycle, and `instrValid` is 0 in the next cycle.
- A redirect takes effect on the edge it is sampled. `imemAddr` reflects the new source in the following cycle.
- Reset asserted mid-operation returns all outputs to their reset values immediately (asynchronously). After release the block sits in IDLE until `fetch`.

## Structure
- Shared package: `fetchSrc` encodings (RST/INT/BR/RET) and state encodings.
- Single module. No sub-module required.
- The 4:1 source mux is inline.

## Test plan
- Reset, then `fetch`=1, `fetchSrc`=00, `extend`=1, memory[0..1] = 16'h0000, 16'h0040 -> reads at 0 and 1, then `imemAddr`=32'h40 on the third cycle, `pc`=32'h40.
- Run 16-bit instructions 16'h1234 at 0x40 and 16'h0567 at 0x41 with `instrReady`=1 -> `instr`=32'h0000_1234 with `instrPC`=0x40, then 32'h0000_0567 with `instrPC`=0x41, 2 cycles apart, `instrExt`=0.
- Memory 0x50 = 16'h8001 and 0x51 = 16'hBEEF, `fetch` with BR, `brTarget`=0x50, `extend`=0 -> `instr`=32'h8001_BEEF, `instrExt`=1, `instrPC`=0x50, next fetch at 0x52.
- `instrReady`=0 for 5 cycles in OUT -> `instr` and `instrPC` stable, `imemRd`=0, then accepted on the 6th cycle.
- `fetch` with INT, `extend`=1 arriving while in INS_HI -> the partial instruction is dropped, no `instrValid`, and `imemAddr`=2 then 3.
- `pc`=32'hFFFF_FFFF holding a 16-bit instruction -> next `imemAddr`=0. Asserting `rst` in the middle of PTR_HI -> all outputs 0 immediately.
